// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_e   : receiver FSM states
//   - STOP_*         : stop_sel encodings, common to both ends of a link
//   - MIN_COMP       : smallest clocks-per-bit value that lets a frame start
//   - DATA_BITS      : data bits per frame
//   - two_stop_bits(): true when a stop_sel value asks for two checked stop bits
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [1:0] STOP_1     = 2'd0;
  localparam logic [1:0] STOP_1P5   = 2'd1;
  localparam logic [1:0] STOP_2     = 2'd2;
  localparam logic [1:0] STOP_2_ALT = 2'd3;

  localparam logic [15:0] MIN_COMP  = 16'd8;
  localparam int unsigned DATA_BITS = 8;

  // 1.5 stop bits only has its first full stop bit checked, so it behaves like 1.
  function automatic logic two_stop_bits(input logic [1:0] sel);
    logic two;
    case (sel)
      STOP_2, STOP_2_ALT: two = 1'b1;
      STOP_1, STOP_1P5:   two = 1'b0;
      default:            two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous serial line.
// Resets to 1 so an idle (high) line does not look like a start edge
// right after reset.
//   clk   in  clock
//   reset in  synchronous, active-high
//   d     in  asynchronous input
//   q     out synchronized output
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous line
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style serial receiver with valid/ack hand-off.
//   clk       in   clock
//   reset     in   synchronous, active-high
//   comp      in   clocks per bit (values below MIN_COMP keep the block idle)
//   stop_sel  in   stop-bit select (see uart_pkg STOP_* encodings)
//   rec_en    in   receiver enable; low aborts any frame in progress
//   uart_rx   in   serial line, idle high, asynchronous
//   rx_data   out  last received byte
//   rx_valid  out  rx_data holds an unread byte
//   rx_ack    in   consumer takes the byte
//   frame_err out  a checked stop bit of the held byte was low
//   overrun   out  one-cycle pulse when an unread byte is overwritten
//   busy      out  a frame is in progress
module uart_receiver
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] comp,
  input  logic [1:0]  stop_sel,
  input  logic        rec_en,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  logic        rx_sync_s;
  logic        rx_prev_r;
  logic        fall_s;
  uart_state_e state_r;
  uart_state_e state_next_s;
  logic [15:0] cnt_r;
  logic [15:0] limit_s;
  logic        last_s;
  logic [15:0] comp_r;
  logic        two_stop_r;
  logic [2:0]  bit_cnt_r;
  logic        stop_cnt_r;
  logic        stop_err_r;
  logic [7:0]  shift_r;
  logic        cnt_clr_s;
  logic        start_s;
  logic        shift_s;
  logic        stop_chk_s;
  logic        deliver_s;

  uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_sync_s)
  );

  assign fall_s = rx_prev_r & ~rx_sync_s;

  // START waits half a bit to land in the middle of the start bit.
  assign limit_s = (state_r == ST_START) ? {1'b0, comp_r[15:1]} : comp_r;
  assign last_s  = (cnt_r == (limit_s - 16'd1));

  // Edge-detector history
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_r <= 1'b1;
    end else begin
      rx_prev_r <= rx_sync_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    cnt_clr_s    = 1'b0;
    start_s      = 1'b0;
    shift_s      = 1'b0;
    stop_chk_s   = 1'b0;
    deliver_s    = 1'b0;
    if (!rec_en) begin
      state_next_s = ST_IDLE;
      cnt_clr_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_clr_s = 1'b1;
          if (fall_s && (comp >= MIN_COMP)) begin
            state_next_s = ST_START;
            start_s      = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (last_s) begin
            cnt_clr_s = 1'b1;
            // A high line mid start bit was a glitch, not a frame.
            if (!rx_sync_s) begin
              state_next_s = ST_DATA;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_START;
          end
        end
        ST_DATA: begin
          if (last_s) begin
            cnt_clr_s = 1'b1;
            shift_s   = 1'b1;
            if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
              state_next_s = ST_STOP;
            end else begin
              state_next_s = ST_DATA;
            end
          end else begin
            state_next_s = ST_DATA;
          end
        end
        ST_STOP: begin
          if (last_s) begin
            cnt_clr_s  = 1'b1;
            stop_chk_s = 1'b1;
            if (!two_stop_r || stop_cnt_r) begin
              state_next_s = ST_IDLE;
              deliver_s    = 1'b1;
            end else begin
              state_next_s = ST_STOP;
            end
          end else begin
            state_next_s = ST_STOP;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_clr_s    = 1'b1;
        end
      endcase
    end
  end

  // Baud counter
  always_ff @(posedge clk) begin
    if (reset || cnt_clr_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // Per-frame settings, frozen at frame start so mid-frame changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      comp_r     <= 16'd0;
      two_stop_r <= 1'b0;
    end else if (start_s) begin
      comp_r     <= comp;
      two_stop_r <= two_stop_bits(stop_sel);
    end
  end

  // Bit/stop counters, shift register and stop-error accumulation
  always_ff @(posedge clk) begin
    if (reset || start_s || !rec_en) begin
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      stop_err_r <= 1'b0;
    end else begin
      if (shift_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (stop_chk_s) begin
        stop_cnt_r <= 1'b1;
        if (!rx_sync_s) begin
          stop_err_r <= 1'b1;
        end
      end
    end
  end

  // LSB arrives first, so each bit enters at the top and moves down.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 8'd0;
    end else if (shift_s) begin
      shift_r <= {rx_sync_s, shift_r[7:1]};
    end
  end

  // Consumer-facing holding registers; a new byte takes priority over an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_s) begin
        rx_data   <= shift_r;
        rx_valid  <= 1'b1;
        frame_err <= stop_err_r | ~rx_sync_s;
        overrun   <= rx_valid & ~rx_ack;
      end else if (rx_valid && rx_ack) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
      end
    end
  end

  // Busy flag follows the state the FSM is heading into
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receiver for 8N1-style frames, the downstream counterpart of `uart_transmitter_sv`: it consumes the `uart_tx` line, recovers each byte and hands it to the consumer through a valid/ack handshake. It uses the same divider (`comp`) and stop-bit (`stop_sel`) controls as the transmitter, so one register block drives both ends of a loopback.

## Interface
- No parameters. Fixed 8 data bits, LSB first, no parity.
- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high.
- `comp`  in  16  clocks per bit, e.g. 50_000_000/115200 = 434. Values below 8 hold the block in IDLE.
- `stop_sel`  in  2  stop-bit select:
  - 0: 1 stop bit.
  - 1: 1.5 stop bits; only the first full stop bit is checked.
  - 2 and 3: 2 stop bits.
- `rec_en`  in  1  receiver enable.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  `rx_data` holds an unread byte.
- `rx_ack`  in  1  consumer accepts the byte.
- `frame_err`  out  1  a checked stop bit of the held byte sampled low.
- `overrun`  out  1  one-cycle pulse: a new byte overwrote an unread byte.
- `busy`  out  1  state is not IDLE.

## Operation
- `uart_rx` passes through a 2-flop synchronizer (reset value 1) and then a falling-edge detector on the synchronized value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge with `rec_en`=1 and `comp`>=8 goes to START, clearing the baud counter.
  - START: after `comp>>1` clocks, sample the line. Low goes to DATA. High is a false start and returns to IDLE with no outputs changed.
  - DATA: sample every `comp` clocks and shift the bit in LSB first (shift register receives bit into [7]). After the 8th sample go to STOP.
  - STOP: sample every `comp` clocks; take 1 sample (`stop_sel` 0 or 1) or 2 samples (2 or 3). Any low sample sets the frame-error flag. After the last sample go to IDLE and deliver the byte.
- Delivery, in the cycle after the last stop sample:
  - `rx_data` <= shift register.
  - `rx_valid` <= 1.
  - `frame_err` <= stop-error flag.
  - `overrun` pulses 1 if `rx_valid` was 1 and `rx_ack` was 0 in that cycle.
- `rx_ack` while `rx_valid`=1: clears `rx_valid` and `frame_err` next cycle. `rx_ack` while `rx_valid`=0 is ignored.
- Ack and delivery in the same cycle: the new byte wins, `rx_valid` stays 1 and there is no overrun.
- `rec_en` is sampled every cycle. When it drops, the FSM returns to IDLE next cycle, the partial frame is discarded and the counters clear. `rx_valid`, `rx_data` and `frame_err` are preserved.
- `comp` and `stop_sel` are sampled into registers when START is entered. Changing them mid-frame does not affect that frame.
- Baud counter is 16 bits and counts 0..N-1, where N is `comp>>1` in START and the registered `comp` otherwise. No wrap hazard, since N < 2^16.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE.
- Let k be the cycle the synchronized falling edge is detected; it lags the pin by 2 clocks.
  - Start sample: k + (`comp`>>1).
  - Data bit i (i = 0..7): k + (`comp`>>1) + (i+1)·`comp`.
  - Stop samples: k + (`comp`>>1) + 9·`comp`, and +10·`comp` when 2 stop bits are checked.
- `rx_valid` rises 1 cycle after the last stop sample.
- `busy` is 1 from k+1 until the cycle the FSM reaches IDLE.
- A new start edge is accepted in the first IDLE cycle; back-to-back frames are supported.
- Reset asserted mid-frame: all outputs return to reset values the next cycle.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state enum (IDLE/START/DATA/STOP).
  - `stop_sel` encodings.
  - `MIN_COMP` = 8.
  - `DATA_BITS` = 8.
  - The transmitter uses the same stop encodings from this package.
- Sub-module `uart_sync`: 2-flop synchronizer with reset value 1.
- Everything else stays in one module.

## Test plan
- Loopback with `uart_transmitter_sv`: 0x55 at comp=434, stop_sel=0 -> `rx_data`=0x55, `rx_valid` rises once, `frame_err`=0, all sample points match the Timing formulas.
- Random bytes with comp in {5208, 2604, 1302, 868, 434} and stop_sel 0..3, 100 frames, acked each time -> every byte matches, no `overrun` or `frame_err`.
- Frame 0xA3 with the stop bit driven low at comp=16 -> `rx_data`=0xA3, `rx_valid`=1, `frame_err`=1 until `rx_ack`. stop_sel=2 with only the second stop low -> `frame_err`=1.
- Glitch: line low for 6 clocks at comp=16 -> false start, `busy` returns to 0, no `rx_valid`.
- Two frames 0x11 then 0x22 with no ack -> one-cycle `overrun` pulse, `rx_data`=0x22. Repeat with ack in the delivery cycle -> no overrun.
- `rec_en` dropped at data bit 4, and `reset` pulsed at data bit 4 -> FSM returns to IDLE. After `rec_en` drop the previously held byte is kept. After reset all outputs are 0. The next full frame is received correctly.
